// File: rtl/if_axi_stream.sv
// Word-serial stream interface shared by the point datapath blocks.
// Ports: dat/val/sop/eop/err/ctl flow source->sink; rdy flows sink->source.
// A word transfers on a cycle where val and rdy are both high.
interface if_axi_stream #(
  parameter int DAT_BITS = 64,
  parameter int CTL_BITS = 8
);
  logic [DAT_BITS-1:0] dat;
  logic                val;
  logic                rdy;
  logic                sop;
  logic                eop;
  logic                err;
  logic [CTL_BITS-1:0] ctl;

  modport source (output dat, val, sop, eop, err, ctl, input  rdy);
  modport sink   (input  dat, val, sop, eop, err, ctl, output rdy);
endinterface

// File: rtl/ec_fpn_acc.sv
// Point accumulator wrapped around ec_fpn_add: sums a batch of Jacobian points.
// Latency: 1 cycle from last adder result eop to first o_pt_if word.
// Backpressure: input stalls outside CAPTURE; adder pair advances only when both rdy; output holds under rdy=0.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-low reset
//   i_pt_if (sink)       input points, LSW first, ctl[0] on eop marks last point of batch
//   o_pt_if (source)     accumulated point per batch, err on eop if any add errored
//   o_add_p1_if (source) running sum to adder operand 1
//   o_add_p2_if (source) new point to adder operand 2
//   i_add_if (sink)      adder result point
//   o_busy               high whenever the FSM is not idle
module ec_fpn_acc #(
  parameter type FP_TYPE       = logic [767:0],
  parameter type FE_TYPE_ARITH = logic [63:0]
) (
  input  logic         i_clk,
  input  logic         i_rst,
  if_axi_stream.sink   i_pt_if,
  if_axi_stream.source o_pt_if,
  if_axi_stream.source o_add_p1_if,
  if_axi_stream.source o_add_p2_if,
  if_axi_stream.sink   i_add_if,
  output logic         o_busy
);

  localparam int ARITH_BITS = $bits(FE_TYPE_ARITH);
  localparam int NUM_WRDS   = $bits(FP_TYPE) / ARITH_BITS;
  localparam int CNT_W      = (NUM_WRDS > 1) ? $clog2(NUM_WRDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WRDS - 1);

  typedef enum logic [2:0] {IDLE, CAPTURE, SEND, WAIT, OUT} state_t;

  state_t r_state;
  state_t w_state_nxt;

  // All-zero ACC is the point at infinity, which the adder passes through.
  logic [NUM_WRDS-1:0][ARITH_BITS-1:0] r_acc;
  logic [NUM_WRDS-1:0][ARITH_BITS-1:0] r_in_buf;
  logic [CNT_W-1:0] r_w_cnt;
  logic [CNT_W-1:0] r_s_cnt;
  logic [CNT_W-1:0] r_r_cnt;
  logic [CNT_W-1:0] r_o_cnt;
  logic             r_err_sticky;
  logic             r_last_l;

  logic             w_in_rdy;
  logic             w_in_fire;
  logic             w_in_take;
  logic [CNT_W-1:0] w_in_idx;
  logic             w_in_at_last;
  logic             w_in_end;
  logic             w_in_bad;
  logic             w_snd_vld;
  logic             w_snd_fire;
  logic             w_res_rdy;
  logic             w_res_fire;
  logic             w_out_vld;
  logic             w_out_fire;
  logic             w_unused;

  // Input side. rdy is gated by reset so nothing is accepted while held in reset.
  assign w_in_rdy  = i_rst && (r_state == IDLE || r_state == CAPTURE);
  assign w_in_fire = w_in_rdy && i_pt_if.val;
  // In IDLE only a sop word opens a point; stray words are dropped.
  assign w_in_take = w_in_fire && (r_state == CAPTURE || i_pt_if.sop);
  // sop always restarts capture at word 0.
  assign w_in_idx     = i_pt_if.sop ? '0 : r_w_cnt;
  assign w_in_at_last = (w_in_idx == LAST);
  // A point ends on eop or on filling the last slot, whichever comes first.
  assign w_in_end  = w_in_take && (i_pt_if.eop || w_in_at_last);
  assign w_in_bad  = w_in_take && ((i_pt_if.sop && r_w_cnt != '0) ||
                                   (i_pt_if.eop != w_in_at_last));

  // Both adder operands move in lockstep: a word only advances when both sides take it.
  assign w_snd_vld  = (r_state == SEND);
  assign w_snd_fire = w_snd_vld && o_add_p1_if.rdy && o_add_p2_if.rdy;

  assign w_res_rdy  = i_rst && (r_state == WAIT);
  assign w_res_fire = w_res_rdy && i_add_if.val;

  // val is constant high in OUT, so (~val || rdy) reduces to rdy.
  assign w_out_vld  = (r_state == OUT);
  assign w_out_fire = w_out_vld && o_pt_if.rdy;

  assign i_pt_if.rdy  = w_in_rdy;
  assign i_add_if.rdy = w_res_rdy;

  assign o_add_p1_if.val = w_snd_vld;
  assign o_add_p1_if.dat = r_acc[r_s_cnt];
  assign o_add_p1_if.sop = w_snd_vld && (r_s_cnt == '0);
  assign o_add_p1_if.eop = w_snd_vld && (r_s_cnt == LAST);
  assign o_add_p1_if.err = 1'b0;
  assign o_add_p1_if.ctl = '0;

  assign o_add_p2_if.val = w_snd_vld;
  assign o_add_p2_if.dat = r_in_buf[r_s_cnt];
  assign o_add_p2_if.sop = w_snd_vld && (r_s_cnt == '0);
  assign o_add_p2_if.eop = w_snd_vld && (r_s_cnt == LAST);
  assign o_add_p2_if.err = 1'b0;
  assign o_add_p2_if.ctl = '0;

  assign o_pt_if.val = w_out_vld;
  assign o_pt_if.dat = r_acc[r_o_cnt];
  assign o_pt_if.sop = w_out_vld && (r_o_cnt == '0);
  assign o_pt_if.eop = w_out_vld && (r_o_cnt == LAST);
  assign o_pt_if.err = w_out_vld && (r_o_cnt == LAST) && r_err_sticky;
  assign o_pt_if.ctl = '0;

  assign o_busy = (r_state != IDLE);

  assign w_unused = &{1'b0, i_pt_if.err, i_pt_if.ctl, i_add_if.sop, i_add_if.ctl};

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_in_end) begin
          w_state_nxt = SEND;
        end else if (w_in_take) begin
          w_state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (w_in_end) begin
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_snd_fire && r_s_cnt == LAST) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (w_res_fire && i_add_if.eop) begin
          w_state_nxt = r_last_l ? OUT : CAPTURE;
        end
      end
      OUT: begin
        if (w_out_fire && r_o_cnt == LAST) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_acc        <= '0;
      r_in_buf     <= '0;
      r_w_cnt      <= '0;
      r_s_cnt      <= '0;
      r_r_cnt      <= '0;
      r_o_cnt      <= '0;
      r_err_sticky <= 1'b0;
      r_last_l     <= 1'b0;
    end else begin
      if (w_in_take) begin
        r_in_buf[w_in_idx] <= i_pt_if.dat;
        if (w_in_end) begin
          r_w_cnt  <= '0;
          r_last_l <= i_pt_if.ctl[0];
        end else begin
          r_w_cnt  <= w_in_idx + 1'b1;
        end
      end

      if (w_snd_fire) begin
        r_s_cnt <= (r_s_cnt == LAST) ? '0 : r_s_cnt + 1'b1;
      end

      // SEND has already streamed ACC out, so overwriting it in place is safe.
      if (w_res_fire) begin
        r_acc[r_r_cnt] <= i_add_if.dat;
        if (i_add_if.eop) begin
          r_r_cnt <= '0;
        end else if (r_r_cnt != LAST) begin
          r_r_cnt <= r_r_cnt + 1'b1;
        end
      end

      if (w_out_fire) begin
        r_o_cnt <= (r_o_cnt == LAST) ? '0 : r_o_cnt + 1'b1;
      end

      if (w_out_fire && r_o_cnt == LAST) begin
        r_acc        <= '0;
        r_err_sticky <= 1'b0;
      end else if (w_in_bad || (w_res_fire && i_add_if.eop && i_add_if.err)) begin
        r_err_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ec_fpn_acc.sv
// Scoreboard bench for ec_fpn_acc with a behavioural adder stand-in.
// The stand-in uses a toy group law (identity at zero, err on equal operands,
// coordinate-wise sum otherwise): the accumulator never inspects arithmetic.
module tb_ec_fpn_acc;

  localparam int NW = 12;

  typedef struct packed {
    logic [255:0] x;
    logic [255:0] y;
    logic [255:0] z;
  } fp_t;

  typedef struct {
    logic [767:0] p1;
    logic [767:0] p2;
  } pair_t;

  typedef struct {
    logic [767:0] pt;
    logic         err;
  } out_t;

  localparam logic [767:0] G  = {256'd1, 256'd2, 256'd1};
  localparam logic [767:0] P  = {{4{64'h1000_0000_0000_0001}},
                                 {4{64'h2000_0000_0000_0002}},
                                 {4{64'h3000_0000_0000_0003}}};
  // G + P under the toy law, worked by hand: only the lowest word of each coord changes.
  localparam logic [767:0] G3 = {{3{64'h1000_0000_0000_0001}}, 64'h1000_0000_0000_0002,
                                 {3{64'h2000_0000_0000_0002}}, 64'h2000_0000_0000_0004,
                                 {3{64'h3000_0000_0000_0003}}, 64'h3000_0000_0000_0004};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  int n_cmp = 0;
  int n_bad = 0;
  int add_cnt = 0;
  int out_cnt = 0;
  bit stall_arm = 1'b0;
  bit out_toggle = 1'b0;

  pair_t exp_add_q[$];
  out_t  exp_out_q[$];

  if_axi_stream #(.DAT_BITS(64)) in_if ();
  if_axi_stream #(.DAT_BITS(64)) out_if ();
  if_axi_stream #(.DAT_BITS(64)) p1_if ();
  if_axi_stream #(.DAT_BITS(64)) p2_if ();
  if_axi_stream #(.DAT_BITS(64)) add_if ();

  ec_fpn_acc #(
    .FP_TYPE      (fp_t),
    .FE_TYPE_ARITH(logic [63:0])
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_pt_if    (in_if),
    .o_pt_if    (out_if),
    .o_add_p1_if(p1_if),
    .o_add_p2_if(p2_if),
    .i_add_if   (add_if),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [767:0] got, input logic [767:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_pair(input logic [767:0] a, input logic [767:0] b);
    pair_t e;
    e.p1 = a;
    e.p2 = b;
    exp_add_q.push_back(e);
  endtask

  task automatic push_out(input logic [767:0] pt, input logic err);
    out_t e;
    e.pt  = pt;
    e.err = err;
    exp_out_q.push_back(e);
  endtask

  function automatic logic [768:0] toy_add(input logic [767:0] a, input logic [767:0] b);
    if (a == '0) return {1'b0, b};
    if (b == '0) return {1'b0, a};
    if (a == b)  return {1'b1, a};
    return {1'b0, a[767:512] + b[767:512], a[511:256] + b[511:256], a[255:0] + b[255:0]};
  endfunction

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send_word(input logic [63:0] d, input logic s, input logic e, input logic c);
    int  t;
    logic ok;
    t = 0;
    ok = 1'b0;
    in_if.val = 1'b1;
    in_if.dat = d;
    in_if.sop = s;
    in_if.eop = e;
    in_if.ctl = {7'b0, c};
    while (!ok) begin
      #2;
      ok = in_if.rdy;
      @(negedge clk);
      t++;
      if (!ok && t > 2000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL input_accept_timeout: got no rdy expected rdy within 2000 cycles");
        ok = 1'b1;
      end
    end
    in_if.val = 1'b0;
    in_if.sop = 1'b0;
    in_if.eop = 1'b0;
  endtask

  task automatic send_point(input logic [767:0] pt, input logic last);
    for (int w = 0; w < NW; w++) begin
      send_word(pt[w*64 +: 64], w == 0, w == NW-1, last);
    end
  endtask

  task automatic wait_out(input int n);
    int t;
    t = 0;
    while (out_cnt < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (out_cnt < n) begin
      n_bad++;
      $display("FAIL output_timeout: got %0d batches expected %0d", out_cnt, n);
    end
  endtask

  task automatic wait_add(input int n);
    int t;
    t = 0;
    while (add_cnt < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (add_cnt < n) begin
      n_bad++;
      $display("FAIL adder_timeout: got %0d pairs expected %0d", add_cnt, n);
    end
  endtask

  // Adder stand-in: collects an operand pair, then returns the result after 3 cycles.
  initial begin : adder_model
    logic [767:0] m_p1;
    logic [767:0] m_p2;
    logic [767:0] m_res;
    logic [768:0] m_sum;
    logic         m_err;
    int  m_widx;
    int  m_ridx;
    int  m_lat;
    int  stall_cnt;
    bit  m_busy;
    pair_t e;
    m_p1 = '0; m_p2 = '0; m_res = '0; m_err = 1'b0;
    m_widx = 0; m_ridx = 0; m_lat = 0; stall_cnt = 0; m_busy = 1'b0;
    p1_if.rdy = 1'b0;
    p2_if.rdy = 1'b0;
    add_if.val = 1'b0; add_if.dat = '0; add_if.sop = 1'b0;
    add_if.eop = 1'b0; add_if.err = 1'b0; add_if.ctl = '0;
    forever begin
      @(negedge clk);
      p1_if.rdy  = !m_busy;
      p2_if.rdy  = !m_busy && (stall_cnt == 0);
      if (stall_cnt > 0) stall_cnt--;
      add_if.val = m_busy && (m_lat == 0);
      add_if.dat = m_res[m_ridx*64 +: 64];
      add_if.sop = (m_ridx == 0);
      add_if.eop = (m_ridx == NW-1);
      add_if.err = m_err && (m_ridx == NW-1);
      if (m_busy && m_lat > 0) m_lat--;
      #2;
      if (!rst_n) begin
        m_widx = 0; m_ridx = 0; m_lat = 0; stall_cnt = 0; m_busy = 1'b0;
      end else begin
        if (p1_if.val || p2_if.val) begin
          chk("add_lockstep", {p1_if.val, p1_if.sop, p1_if.eop}, {p2_if.val, p2_if.sop, p2_if.eop});
        end
        if (p1_if.val && p2_if.val && p1_if.rdy && p2_if.rdy && m_widx < NW) begin
          chk("add_sop", p1_if.sop, m_widx == 0);
          m_p1[m_widx*64 +: 64] = p1_if.dat;
          m_p2[m_widx*64 +: 64] = p2_if.dat;
          if (stall_arm && m_widx == 5) begin
            stall_cnt = 5;
            stall_arm = 1'b0;
          end
          if (p1_if.eop) begin
            add_cnt++;
            if (exp_add_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL add_unexpected: got pair %0d expected none", add_cnt);
            end else begin
              e = exp_add_q.pop_front();
              chk("add_pt1", m_p1, e.p1);
              chk("add_pt2", m_p2, e.p2);
            end
            m_sum  = toy_add(m_p1, m_p2);
            m_res  = m_sum[767:0];
            m_err  = m_sum[768];
            m_busy = 1'b1;
            m_lat  = 3;
            m_ridx = 0;
            m_widx = 0;
          end else begin
            m_widx++;
          end
        end
        if (add_if.val && add_if.rdy) begin
          if (m_ridx == NW-1) begin
            m_busy = 1'b0;
            m_ridx = 0;
          end else begin
            m_ridx++;
          end
        end
      end
    end
  end

  initial begin : out_rdy_drv
    out_if.rdy = 1'b1;
    forever begin
      @(negedge clk);
      out_if.rdy = out_toggle ? ~out_if.rdy : 1'b1;
    end
  end

  initial begin : out_mon
    int oidx;
    logic [767:0] got_pt;
    out_t e;
    oidx = 0;
    got_pt = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        oidx = 0;
      end else if (out_if.val && out_if.rdy) begin
        chk("out_sop", out_if.sop, oidx == 0);
        if (oidx < NW) got_pt[oidx*64 +: 64] = out_if.dat;
        if (out_if.eop) begin
          chk("out_busy_at_eop", busy, 1'b1);
          chk("out_word_count", oidx + 1, NW);
          if (exp_out_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL out_unexpected: got batch %0h expected none", got_pt);
          end else begin
            e = exp_out_q.pop_front();
            chk("out_pt", got_pt, e.pt);
            chk("out_err", out_if.err, e.err);
          end
          oidx = 0;
          out_cnt++;
        end else begin
          oidx++;
        end
      end
    end
  end

  initial begin : main
    int base_add;
    int base_out;
    in_if.val = 1'b0; in_if.dat = '0; in_if.sop = 1'b0;
    in_if.eop = 1'b0; in_if.err = 1'b0; in_if.ctl = '0;

    repeat (3) @(negedge clk);
    #2;
    chk("rst_busy",    busy,       1'b0);
    chk("rst_in_rdy",  in_if.rdy,  1'b0);
    chk("rst_out_val", out_if.val, 1'b0);
    chk("rst_p1_val",  p1_if.val,  1'b0);
    chk("rst_add_rdy", add_if.rdy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    chk("idle_in_rdy", in_if.rdy, 1'b1);
    @(negedge clk);

    // Single point passes through unchanged.
    base_add = add_cnt; base_out = out_cnt;
    push_pair('0, G);
    push_out(G, 1'b0);
    send_point(G, 1'b1);
    wait_out(base_out + 1);
    chk("single_add_count", add_cnt - base_add, 1);
    chk("single_idle", busy, 1'b0);

    // Two-point batch with p2 stalled for 5 cycles mid-SEND.
    base_add = add_cnt; base_out = out_cnt;
    stall_arm = 1'b1;
    push_pair('0, G);
    push_pair(G, P);
    push_out(G3, 1'b0);
    send_point(G, 1'b0);
    chk("pair_busy_mid", busy, 1'b1);
    send_point(P, 1'b1);
    wait_out(base_out + 1);
    chk("pair_add_count", add_cnt - base_add, 2);
    chk("pair_idle", busy, 1'b0);

    // Equal operands: adder err must reach the batch output.
    base_out = out_cnt;
    push_pair('0, G);
    push_pair(G, G);
    push_out(G, 1'b1);
    send_point(G, 1'b0);
    send_point(G, 1'b1);
    wait_out(base_out + 1);

    // Sticky err cleared; output rdy toggling 1010.
    base_out = out_cnt;
    out_toggle = 1'b1;
    push_pair('0, G);
    push_out(G, 1'b0);
    send_point(G, 1'b1);
    wait_out(base_out + 1);
    out_toggle = 1'b0;

    // Reset during WAIT of the second point.
    base_add = add_cnt;
    push_pair('0, G);
    push_pair(G, P);
    send_point(G, 1'b0);
    send_point(P, 1'b1);
    wait_add(base_add + 2);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #2;
    chk("mid_rst_busy",    busy,       1'b0);
    chk("mid_rst_in_rdy",  in_if.rdy,  1'b0);
    chk("mid_rst_out_val", out_if.val, 1'b0);
    chk("mid_rst_p1_val",  p1_if.val,  1'b0);
    chk("mid_rst_p2_val",  p2_if.val,  1'b0);
    chk("mid_rst_add_rdy", add_if.rdy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    base_out = out_cnt;
    push_pair('0, G);
    push_out(G, 1'b0);
    send_point(G, 1'b1);
    wait_out(base_out + 1);

    // Malformed: sop arrives at word 5, capture restarts and err is flagged.
    base_out = out_cnt;
    push_pair('0, G);
    push_out(G, 1'b1);
    for (int w = 0; w < 5; w++) begin
      send_word(P[w*64 +: 64], w == 0, 1'b0, 1'b0);
    end
    send_point(G, 1'b1);
    wait_out(base_out + 1);

    repeat (5) @(negedge clk);
    chk("leftover_add_exp", exp_add_q.size(), 0);
    chk("leftover_out_exp", exp_out_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ec_fpn_acc.md
Name: ec_fpn_acc

Overview:
- Point accumulator sitting directly around ec_fpn_add. It consumes a stream of Jacobian points and feeds the adder with (running sum, new point) pairs.
- It takes each adder result back as the new running sum. When a batch ends, it streams the final sum out.
- All point traffic is word-serial at ARITH_BITS, so downstream MSM / bucket logic sees one summed point per batch.

Parameters:
- FP_TYPE, (none, required), Jacobian point struct {x,y,z}; flattened width $bits(FP_TYPE).
- FE_TYPE_ARITH, (none, required), arithmetic word type; ARITH_BITS = $bits(FE_TYPE_ARITH).
- NUM_WRDS, $bits(FP_TYPE)/ARITH_BITS, words per point (derived localparam, not overridable).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-low
- i_pt_if  if_axi_stream.sink  dat ARITH_BITS  input points, word 0 (LSW) first; ctl[0] on eop word = last point of batch
- o_pt_if  if_axi_stream.source  dat ARITH_BITS  accumulated point per batch; err set on eop if any add in batch errored
- o_add_p1_if  if_axi_stream.source  dat ARITH_BITS  running sum to adder pt1
- o_add_p2_if  if_axi_stream.source  dat ARITH_BITS  new point to adder pt2
- i_add_if  if_axi_stream.sink  dat ARITH_BITS  adder result point
- o_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (i_rst==0 at posedge):
  - all source val/sop/eop/err = 0; i_pt_if.rdy = 0; i_add_if.rdy = 0.
  - ACC = 0 (all-zero = point at infinity; the adder passes the other operand through).
  - IN_BUF = 0, counters = 0, err_sticky = 0, last_l = 0, state = IDLE.
  - A reset mid-operation discards any partial batch. The adder shares the reset.
- States: IDLE -> CAPTURE -> SEND -> WAIT -> (CAPTURE | OUT) -> IDLE.
- IDLE: i_pt_if.rdy = 1. The first accepted word, which must carry sop, moves to CAPTURE with that word stored.
- CAPTURE:
  - i_pt_if.rdy = 1; each accepted word shifts into IN_BUF[w_cnt].
  - On the eop word (w_cnt == NUM_WRDS-1): latch last_l = ctl[0], w_cnt = 0, go to SEND.
  - sop arriving with w_cnt != 0: restart at word 0 and set err_sticky.
  - eop arriving with w_cnt != NUM_WRDS-1: set err_sticky and treat as end of point.
- SEND:
  - o_add_p1_if and o_add_p2_if present ACC word s_cnt and IN_BUF word s_cnt with identical val/sop/eop, changing only on the cycle both rdy are high. This is the lockstep the adder requires, since its rdy needs both val.
  - sop on s_cnt==0, eop on s_cnt==NUM_WRDS-1. After the eop handshake go to WAIT.
  - i_pt_if.rdy = 0 in SEND, WAIT and OUT.
- WAIT:
  - i_add_if.rdy = 1; each result word writes ACC[r_cnt]. ACC is updated in place; SEND has completed, so no hazard.
  - err on the result eop word ORs into err_sticky.
  - After the eop word: go to OUT if last_l, else go to CAPTURE.
  - i_add_if.val outside WAIT is ignored, rdy stays 0.
- OUT:
  - Stream ACC words 0..NUM_WRDS-1 on o_pt_if, sop on first, eop on last, err = err_sticky on the eop word.
  - Advance on (~val || rdy). Holding dat/val while rdy=0 is mandatory.
  - After the eop handshake: ACC = 0, err_sticky = 0, state = IDLE.
- Throughput per point: NUM_WRDS capture + NUM_WRDS send + adder latency + NUM_WRDS receive cycles, minimum, with no backpressure.
- Latency from last result eop to o_pt_if first val: 1 cycle.
- Batch of one point: ACC = 0, so the adder returns the point unchanged and the output equals the input.
- Equal operands (doubling not supported by adder): the adder returns pt1 with err. The block keeps the returned ACC and reports err at batch end.

Test Plan:
- ARITH_BITS=64, 256-bit coords (NUM_WRDS=12). Single point G=(1,2,1) with ctl[0]=1 -> o_pt_if emits 12 words equal to G; err=0; exactly one pair sent to adder, with pt1 all zero.
- Batch {G, 2G_jac} -> output equals golden Jacobian 3G from the model adder. Exactly two adder transactions; o_busy high from first accept to last output handshake.
- Batch {G, G} -> adder err propagates; output = G with err=1 on eop; next batch {G} outputs G with err=0, confirming sticky err cleared.
- Backpressure: o_add_p2_if.rdy low for 5 cycles mid-SEND while p1 rdy high -> both streams hold word index together; no word skipped or duplicated. o_pt_if.rdy toggling 1010 -> all 12 words delivered in order.
- Reset asserted (i_rst=0) during WAIT of the second point -> all outputs 0 next cycle; fresh batch {G} afterwards outputs G.
- Malformed input: sop at word 5 of a point -> capture restarts; batch output carries err=1.
